// File: rtl/cache_pkg.sv
// Shared types and constants for the cache line-fill reader.
package cache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } t_line_rd_state;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    localparam int DEF_ADDR_WIDTH  = 64;
    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_BLOCK_WORDS = 16;

endpackage

// File: rtl/cache_line_reader_line_buffer.sv
// Beat-slot storage for one cache line with indexed write decode.
module line_buffer #(
    parameter int DATA_WIDTH  = 32,
    parameter int BLOCK_WORDS = 16,
    parameter int IDX_W       = $clog2(BLOCK_WORDS)
) (
    input  logic                              clk,
    input  logic                              arstn,
    input  logic                              i_we,
    input  logic [IDX_W-1:0]                  i_idx,
    input  logic [DATA_WIDTH-1:0]             i_wdata,
    input  logic                              i_clr,
    output logic [BLOCK_WORDS*DATA_WIDTH-1:0] o_block
);

    logic [BLOCK_WORDS-1:0][DATA_WIDTH-1:0] slot_q, slot_d;

    // Clear and write may coincide: the write wins for its own slot.
    always_comb begin
        slot_d = slot_q;
        if (i_clr) slot_d = '0;
        for (int k = 0; k < BLOCK_WORDS; k++) begin
            if (i_we && (i_idx == IDX_W'(k))) slot_d[k] = i_wdata;
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) slot_q <= '0;
        else        slot_q <= slot_d;
    end

    assign o_block = slot_q;

endmodule

// File: rtl/cache_line_reader.sv
// AXI4 line-fill reader: one INCR burst per request, assembled into a full line.
// Optional rresp/rlast checking is enabled by defining CACHE_LINE_READER_RRESP_CHECK_EN.
module cache_line_reader
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int BLOCK_WORDS = DEF_BLOCK_WORDS
) (
    input  logic                              clk,
    input  logic                              arstn,
    input  logic                              i_start_read,
    input  logic [ADDR_WIDTH-1:0]             i_addr,
    output logic                              o_r_last,
    output logic [BLOCK_WORDS*DATA_WIDTH-1:0] o_data_block,
    output logic                              o_arvalid,
    input  logic                              i_arready,
    output logic [ADDR_WIDTH-1:0]             o_araddr,
    output logic [7:0]                        o_arlen,
    output logic [2:0]                        o_arsize,
    output logic [1:0]                        o_arburst,
    input  logic                              i_rvalid,
    output logic                              o_rready,
    input  logic [DATA_WIDTH-1:0]             i_rdata,
    input  logic                              i_rlast,
    input  logic [1:0]                        i_rresp,
    output logic                              o_access_fault
);

    localparam int IDX_W      = $clog2(BLOCK_WORDS);
    localparam int LINE_BYTES = BLOCK_WORDS * DATA_WIDTH / 8;
    localparam int OFFS_W     = $clog2(LINE_BYTES);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {ADDR_WIDTH{1'b1}} << OFFS_W;
    localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(BLOCK_WORDS - 1);

    t_line_rd_state          state_q, state_d;
    logic [IDX_W-1:0]        cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    beat_we;
    logic                    fill_start;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        beat_we    = 1'b0;
        fill_start = 1'b0;
        o_arvalid  = 1'b0;
        o_rready   = 1'b0;
        o_r_last   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (i_start_read) begin
                    fill_start = 1'b1;
                    addr_d     = i_addr & ALIGN_MASK;
                    cnt_d      = '0;
                    state_d    = ST_ADDR;
                end
            end
            ST_ADDR: begin
                o_arvalid = 1'b1;
                if (i_arready) state_d = ST_DATA;
            end
            ST_DATA: begin
                o_rready = 1'b1;
                // Completion follows our own beat count; rlast is only a cross-check.
                if (i_rvalid) begin
                    beat_we = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == LAST_IDX) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                o_r_last = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
        end
    end

    assign o_araddr  = addr_q;
    assign o_arlen   = 8'(BLOCK_WORDS - 1);
    assign o_arsize  = 3'($clog2(DATA_WIDTH / 8));
    assign o_arburst = AXI_BURST_INCR;

    // Previous line stays visible until beat 0 of the next fill lands; then stale beats are wiped.
    line_buffer #(
        .DATA_WIDTH  (DATA_WIDTH),
        .BLOCK_WORDS (BLOCK_WORDS),
        .IDX_W       (IDX_W)
    ) u_line_buffer (
        .clk     (clk),
        .arstn   (arstn),
        .i_we    (beat_we),
        .i_idx   (cnt_q),
        .i_wdata (i_rdata),
        .i_clr   (beat_we && (cnt_q == '0)),
        .o_block (o_data_block)
    );

`ifdef CACHE_LINE_READER_RRESP_CHECK_EN
    logic fault_q, fault_d;

    always_comb begin
        fault_d = fault_q;
        if (fill_start)
            fault_d = 1'b0;
        else if (beat_we && ((i_rresp != AXI_RESP_OKAY) || (i_rlast != (cnt_q == LAST_IDX))))
            fault_d = 1'b1;
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) fault_q <= 1'b0;
        else        fault_q <= fault_d;
    end

    assign o_access_fault = fault_q;
`else
    logic unused_rchk;
    assign unused_rchk    = ^{i_rresp, i_rlast, fill_start};
    assign o_access_fault = 1'b0;
`endif

endmodule

// File: tb/tb_cache_line_reader.sv
// Randomized self-checking bench for cache_line_reader with an in-bench AXI slave model.
module tb_cache_line_reader;

    localparam int AW = 64;
    localparam int DW = 32;
    localparam int BW = 16;

`ifdef CACHE_LINE_READER_RRESP_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             arstn = 1'b0;
    logic             start = 1'b0;
    logic [AW-1:0]    addr_in = '0;
    logic             r_last;
    logic [BW*DW-1:0] blk;
    logic             arvalid;
    logic             arready = 1'b0;
    logic [AW-1:0]    araddr;
    logic [7:0]       arlen;
    logic [2:0]       arsize;
    logic [1:0]       arburst;
    logic             rvalid = 1'b0;
    logic             rready;
    logic [DW-1:0]    rdata = '0;
    logic             rlast = 1'b0;
    logic [1:0]       rresp = 2'b00;
    logic             fault;

    int tests = 0;
    int fails = 0;
    int ar_hs_cnt = 0;
    int rlast_cnt = 0;
    logic [BW*DW-1:0] last_blk;

    always #5 clk = ~clk;

    cache_line_reader dut (
        .clk(clk), .arstn(arstn), .i_start_read(start), .i_addr(addr_in),
        .o_r_last(r_last), .o_data_block(blk),
        .o_arvalid(arvalid), .i_arready(arready), .o_araddr(araddr),
        .o_arlen(arlen), .o_arsize(arsize), .o_arburst(arburst),
        .i_rvalid(rvalid), .o_rready(rready), .i_rdata(rdata),
        .i_rlast(rlast), .i_rresp(rresp), .o_access_fault(fault)
    );

    always @(posedge clk) begin
        if (arvalid && arready) ar_hs_cnt <= ar_hs_cnt + 1;
        if (r_last) rlast_cnt <= rlast_cnt + 1;
    end

    // One full line fill, driven as an AXI slave plus cache FSM; the model is a plain word array.
    task automatic do_fill(input logic [AW-1:0] addr, input int ar_delay, input int gap_a,
                           input int gap_b, input int bad_beat, input bit bad_rlast,
                           input bit drop_early, input int abort_at, input bit seq_data);
        logic [DW-1:0]    words [BW];
        logic [BW*DW-1:0] exp_blk;
        logic [AW-1:0]    exp_addr;
        bit exp_fault, gapped, acc;
        int ar0, rl0, k;
        exp_addr = addr & ~64'h3F;
        for (int i = 0; i < BW; i++) words[i] = seq_data ? DW'(i) : DW'($urandom);
        for (int i = 0; i < BW; i++) exp_blk[i*DW +: DW] = words[i];
        ar0 = ar_hs_cnt;
        rl0 = rlast_cnt;
        @(negedge clk);
        start = 1'b1;
        addr_in = addr;
        @(negedge clk);
        exp_fault = 1'b0;
        for (int c = 0; c <= ar_delay; c++) begin
            tests++;
            if (arvalid !== 1'b1 || araddr !== exp_addr || arlen !== 8'd15 || arsize !== 3'd2 ||
                arburst !== 2'b01 || rready !== 1'b0 || r_last !== 1'b0 || fault !== 1'b0)
                begin fails++; $display("FAIL ar_phase: arvalid=%b araddr=%h len=%0d size=%0d burst=%0d fault=%b exp araddr=%h", arvalid, araddr, arlen, arsize, arburst, fault, exp_addr); end
            arready = (c == ar_delay);
            @(negedge clk);
        end
        arready = 1'b0;
        if (drop_early) start = 1'b0;
        k = 0;
        gapped = 1'b0;
        while (k < BW) begin
            tests++;
            if (rready !== 1'b1 || arvalid !== 1'b0 || r_last !== 1'b0 || fault !== exp_fault)
                begin fails++; $display("FAIL data_phase beat %0d: rready=%b arvalid=%b r_last=%b fault=%b exp fault=%b", k, rready, arvalid, r_last, fault, exp_fault); end
            acc = 1'b0;
            if ((k == gap_a || k == gap_b) && !gapped) begin
                rvalid = 1'b0;
                gapped = 1'b1;
            end else begin
                rvalid = 1'b1;
                rdata  = words[k];
                rresp  = (k == bad_beat) ? 2'b10 : 2'b00;
                rlast  = bad_rlast ? 1'b0 : (k == BW - 1);
                if (CHK_EN && (k == bad_beat || (bad_rlast && k == BW - 1))) exp_fault = 1'b1;
                gapped = 1'b0;
                acc = 1'b1;
                k++;
            end
            @(negedge clk);
            if (acc && (k - 1 == abort_at)) begin
                rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
                arstn = 1'b0;
                #1;
                tests++;
                if (arvalid !== 1'b0 || rready !== 1'b0 || r_last !== 1'b0 || fault !== 1'b0 || blk !== '0)
                    begin fails++; $display("FAIL abort_reset: arvalid=%b rready=%b r_last=%b fault=%b blk_nonzero=%b", arvalid, rready, r_last, fault, |blk); end
                start = 1'b0;
                @(negedge clk);
                arstn = 1'b1;
                @(negedge clk);
                tests++;
                if (arvalid !== 1'b0 || rready !== 1'b0 || r_last !== 1'b0)
                    begin fails++; $display("FAIL abort_idle: arvalid=%b rready=%b r_last=%b exp 0", arvalid, rready, r_last); end
                return;
            end
        end
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
        tests++;
        if (r_last !== 1'b1 || arvalid !== 1'b0 || rready !== 1'b0 || blk !== exp_blk || fault !== exp_fault)
            begin fails++; $display("FAIL done: r_last=%b arvalid=%b rready=%b fault=%b exp fault=%b blk=%h exp=%h", r_last, arvalid, rready, fault, exp_fault, blk, exp_blk); end
        start = 1'b0;
        @(negedge clk);
        tests++;
        if (r_last !== 1'b0 || blk !== exp_blk || fault !== exp_fault ||
            rlast_cnt - rl0 != 1 || ar_hs_cnt - ar0 != 1)
            begin fails++; $display("FAIL post_done: r_last=%b fault=%b ar_hs=%0d rlast_pulses=%0d exp 1/1", r_last, fault, ar_hs_cnt - ar0, rlast_cnt - rl0); end
        last_blk = exp_blk;
    endtask

    task automatic test_reset();
        #2;
        tests++;
        if (arvalid !== 1'b0 || rready !== 1'b0 || r_last !== 1'b0 || fault !== 1'b0 ||
            blk !== '0 || araddr !== '0)
            begin fails++; $display("FAIL reset: arvalid=%b rready=%b r_last=%b fault=%b araddr=%h", arvalid, rready, r_last, fault, araddr); end
        @(negedge clk);
        arstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_addr_fields();
        do_fill(64'h1234, 0, -1, -1, -1, 1'b0, 1'b0, -1, 1'b0);
        tests++;
        if (araddr !== 64'h1200)
            begin fails++; $display("FAIL addr_align: araddr=%h exp 1200", araddr); end
    endtask

    task automatic test_back_to_back_beats();
        do_fill(64'hFFFF_0000_0000_007F, 0, -1, -1, -1, 1'b0, 1'b0, -1, 1'b1);
        tests++;
        if (blk[31:0] !== 32'd0 || blk[511:480] !== 32'd15)
            begin fails++; $display("FAIL seq_slots: slot0=%h slot15=%h exp 0/f", blk[31:0], blk[511:480]); end
    endtask

    task automatic test_stalls();
        do_fill(64'hABCD_EF01_2345_6789, 5, 3, 9, -1, 1'b0, 1'b0, -1, 1'b0);
    endtask

    task automatic test_fault();
        do_fill(64'h40, 0, -1, -1, 7, 1'b0, 1'b0, -1, 1'b0);
        do_fill(64'h80, 1, 2, -1, -1, 1'b1, 1'b0, -1, 1'b0);
        do_fill(64'hC0, 0, -1, -1, -1, 1'b0, 1'b0, -1, 1'b0);
    endtask

    task automatic test_abort();
        do_fill(64'h5555, 2, -1, -1, -1, 1'b0, 1'b0, 8, 1'b0);
        do_fill(64'h7777, 0, 4, -1, -1, 1'b0, 1'b0, -1, 1'b0);
    endtask

    task automatic test_drop_early();
        do_fill(64'h9000, 3, 0, 15, -1, 1'b0, 1'b1, -1, 1'b0);
    endtask

    task automatic test_back_to_back_fills();
        int ar0, rl0;
        ar0 = ar_hs_cnt;
        rl0 = rlast_cnt;
        do_fill(64'h1000, 0, -1, -1, -1, 1'b0, 1'b0, -1, 1'b0);
        do_fill(64'h2040, 0, -1, -1, -1, 1'b0, 1'b0, -1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (arvalid !== 1'b0 || rready !== 1'b0 || blk !== last_blk)
                begin fails++; $display("FAIL idle_hold cycle %0d: arvalid=%b rready=%b", i, arvalid, rready); end
            @(negedge clk);
        end
        tests++;
        if (ar_hs_cnt - ar0 != 2 || rlast_cnt - rl0 != 2)
            begin fails++; $display("FAIL two_fills: ar_hs=%0d rlast=%0d exp 2/2", ar_hs_cnt - ar0, rlast_cnt - rl0); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            logic [AW-1:0] a;
            a = {$urandom, $urandom};
            do_fill(a, $urandom_range(0, 4),
                    ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 15)) : -1,
                    ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 15)) : -1,
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1,
                    1'b0, $urandom_range(0, 1) != 0, -1, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_addr_fields();
        test_back_to_back_beats();
        test_stalls();
        test_fault();
        test_abort();
        test_drop_early();
        test_back_to_back_fills();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cache_line_reader.md
CACHE_LINE_READER -- requirements
Module: cache_line_reader

Interface
REQ-001 Parameter ADDR_WIDTH, default 64, byte address width.
REQ-002 Parameter DATA_WIDTH, default 32, AXI read-data beat width in bits.
REQ-003 Parameter BLOCK_WORDS, default 16, beats per cache line (power of two, 2..256).
REQ-004 clk  input  1  clock, rising edge.
REQ-005 arstn  input  1  reset, asynchronous, active-low.
REQ-006 i_start_read  input  1  line-fill request from the cache FSM; level, held high until o_r_last is seen.
REQ-007 i_addr  input  ADDR_WIDTH  miss address; sampled in IDLE when i_start_read is high.
REQ-008 o_r_last  output  1  one-cycle pulse: the whole line is valid on o_data_block.
REQ-009 o_data_block  output  BLOCK_WORDS*DATA_WIDTH  assembled line; beat k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-010 o_arvalid / i_arready  output / input  1 / 1  AXI4 AR handshake.
REQ-011 o_araddr  output  ADDR_WIDTH  line-aligned burst start address.
REQ-012 o_arlen, o_arsize, o_arburst  output  8, 3, 2  burst length, beat size, burst type.
REQ-013 i_rvalid / o_rready  input / output  1 / 1  AXI4 R handshake.
REQ-014 i_rdata, i_rlast, i_rresp  input  DATA_WIDTH, 1, 2  AXI4 R beat payload.
REQ-015 o_access_fault  output  1  sticky error flag (see Configuration).

Function
REQ-016 The FSM SHALL have the states IDLE, ADDR, DATA and DONE.
REQ-017 In IDLE with i_start_read=1, the block SHALL latch i_addr with its low log2(BLOCK_WORDS*DATA_WIDTH/8) bits zeroed into the address register, clear the beat counter, and go to ADDR.
REQ-018 ADDR: o_arvalid=1, o_araddr constant; o_arlen=BLOCK_WORDS-1, o_arsize=log2(DATA_WIDTH/8), o_arburst=2'b01 (INCR) at all times; on i_arready=1 go to DATA.
REQ-019 DATA: o_rready=1; each cycle with i_rvalid=1, i_rdata SHALL be written to beat slot [counter] and the counter incremented.
REQ-020 Completion SHALL be decided by the internal counter: the beat accepted at counter=BLOCK_WORDS-1 moves the FSM to DONE, whatever the value of i_rlast.
REQ-021 DONE: o_r_last=1 for exactly one cycle; the next state SHALL be IDLE unconditionally. Fill latency is therefore last R beat + 1 cycle.
REQ-022 o_data_block SHALL hold its value from DONE until the next fill writes beat 0; it SHALL NOT change during the o_r_last cycle.
REQ-023 i_start_read high in the cycle after DONE (IDLE) SHALL start a new fill. The cache FSM drops the request in that cycle, so no repeated fill occurs.
REQ-024 i_start_read falling in ADDR or DATA SHALL NOT abort the burst, because AXI forbids abandoning a burst. The fill completes and o_r_last still pulses.
REQ-025 o_arvalid SHALL be 1 only in ADDR, o_rready only in DATA, o_r_last only in DONE. All three are driven combinationally from the state register.
REQ-026 Back-to-back beats (i_rvalid=1 every cycle) SHALL be accepted at one beat per cycle, with no bubbles.

Reset
REQ-027 When arstn is low, the FSM SHALL go to IDLE and the counter, address register, o_data_block and o_access_fault SHALL clear to 0. The outputs o_arvalid, o_rready and o_r_last SHALL then be 0.
REQ-028 Reset during ADDR or DATA SHALL abandon the fill immediately. Handling of the AXI slave is a system-level reset requirement.

Configuration
REQ-029 With the macro CACHE_LINE_READER_RRESP_CHECK_EN defined, o_access_fault SHALL be set and stay set until the next IDLE-to-ADDR transition in two cases:
- an accepted beat has i_rresp != 2'b00;
- i_rlast disagrees with (counter == BLOCK_WORDS-1).
The fill completes normally in both cases.
REQ-030 With the macro undefined, i_rresp and i_rlast SHALL be ignored and o_access_fault SHALL be tied to 0.

Structure
REQ-031 The shared package cache_pkg SHALL hold:
- the state enum t_line_rd_state;
- the constant AXI_BURST_INCR = 2'b01;
- the AXI_RESP_OKAY constant;
- the default widths.
REQ-032 The beat-slot storage and write decode SHALL be the sub-module line_buffer (inputs: write enable, index, data, clear).

Verification
REQ-033 Fill with i_addr=0x1234 and defaults -> o_araddr=0x1200, o_arlen=15, o_arsize=2, o_arburst=1, one AR handshake.
REQ-034 Sixteen back-to-back beats with rdata=k -> o_r_last pulses one cycle after beat 15; o_data_block[31:0]=0 and [511:480]=15.
REQ-035 i_arready delayed 5 cycles and i_rvalid gaps on beats 3 and 9 -> o_arvalid stays high and stable, beats are stored in order, one o_r_last pulse.
REQ-036 Macro defined, beat 7 has rresp=2'b10 -> o_access_fault rises after beat 7 and clears at the next fill start. Macro undefined -> o_access_fault stays 0.
REQ-037 arstn asserted after beat 8 -> FSM in IDLE, all outputs 0; a following fill completes correctly.
REQ-038 Two consecutive fills driven by a model of the cache FSM -> exactly two AR handshakes and two o_r_last pulses, with no spurious third request.
